// File: rtl/led_display_pkg.sv
// Types and one-hot helpers shared by the 7-segment bus driver and its capture block.
package led_display_pkg;

  typedef logic [7:0] seg_t;

  // Widest select bus the helpers accept; narrower buses are zero-extended by the caller.
  localparam int MAX_DIGITS = 32;

  function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - MAX_DIGITS'(1))) == '0);
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_DIGITS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_capture_filter.sv
// Samples the asynchronous seg/sel bus, normalises it to active-high and emits one
// commit for every word that stays unchanged long enough with a one-hot select.
module led_capture_filter
  import led_display_pkg::*;
#(
  parameter int   NUM           = 8,
  parameter logic VALID_SIGNAL  = 1'b0,
  parameter int   STABLE_CYCLES = 16,
  parameter int   IDX_W         = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [7:0]       i_seg,
  input  logic [NUM-1:0]   i_sel,
  output logic             o_commit,
  output logic [IDX_W-1:0] o_commit_idx,
  output seg_t             o_commit_seg
);

  localparam int            CW         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_PRE = CW'(STABLE_CYCLES - 1);
  localparam logic          INV        = (VALID_SIGNAL == 1'b0);

  logic [7:0]     r_seg_s1, r_seg_s2;
  logic [NUM-1:0] r_sel_s1, r_sel_s2;
  logic [NUM+7:0] r_word_prev;
  logic [CW-1:0]  r_stab_cnt;

  logic [7:0]            w_seg_n;
  logic [NUM-1:0]        w_sel_n;
  logic [NUM+7:0]        w_word;
  logic [MAX_DIGITS-1:0] w_sel_ext;
  logic                  w_same;
  logic                  w_reach;

  assign w_seg_n   = r_seg_s2 ^ {8{INV}};
  assign w_sel_n   = r_sel_s2 ^ {NUM{INV}};
  assign w_word    = {w_sel_n, w_seg_n};
  assign w_sel_ext = MAX_DIGITS'(w_sel_n);
  assign w_same    = (w_word == r_word_prev);
  // The counter holds the length of the current run of identical samples; it reaches
  // STABLE_CYCLES once, on the STABLE_CYCLES-th sample, and then saturates.
  assign w_reach   = w_same && (r_stab_cnt == STABLE_PRE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_seg_s1     <= '0;
      r_seg_s2     <= '0;
      r_sel_s1     <= '0;
      r_sel_s2     <= '0;
      r_word_prev  <= '0;
      r_stab_cnt   <= '0;
      o_commit     <= 1'b0;
      o_commit_idx <= '0;
      o_commit_seg <= '0;
    end else begin
      r_seg_s1    <= i_seg;
      r_seg_s2    <= r_seg_s1;
      r_sel_s1    <= i_sel;
      r_sel_s2    <= r_sel_s1;
      r_word_prev <= w_word;
      if (!w_same) begin
        r_stab_cnt <= CW'(1);
      end else if (r_stab_cnt != STABLE_MAX) begin
        r_stab_cnt <= r_stab_cnt + CW'(1);
      end
      o_commit     <= w_reach && is_onehot(w_sel_ext);
      o_commit_idx <= IDX_W'(onehot_to_idx(w_sel_ext));
      o_commit_seg <= w_seg_n;
    end
  end

endmodule

// File: rtl/led_display_capture.sv
// Rebuilds per-digit segment values from a multiplexed 7-seg bus, with per-digit
// refresh timeout, change pulse and frame-complete pulse.
module led_display_capture
  import led_display_pkg::*;
#(
  parameter int   NUM            = 8,
  parameter logic VALID_SIGNAL   = 1'b0,
  parameter int   STABLE_CYCLES  = 16,
  parameter int   TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               external_clk,
  input  logic               external_rstn,
  input  logic [7:0]         led_display_seg,
  input  logic [NUM-1:0]     led_display_sel,
  output seg_t [NUM-1:0]     led_out,
  output logic [NUM-1:0]     digit_valid,
  output logic               led_update,
  output logic               frame_done
);

  localparam int            IDX_W   = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int            AW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] AGE_PRE = AW'(TIMEOUT_CYCLES - 1);

  logic             w_commit;
  logic [IDX_W-1:0] w_commit_idx;
  seg_t             w_commit_seg;

  seg_t [NUM-1:0]   r_led;
  logic [NUM-1:0]   r_valid;
  logic [NUM-1:0]   r_seen;
  logic             r_update;
  logic             r_frame_done;

  seg_t [NUM-1:0]   w_led_next;
  logic [NUM-1:0]   w_valid_next;
  logic [NUM-1:0]   w_commit_oh;
  logic [NUM-1:0]   w_seen_next;

  led_capture_filter #(
    .NUM          (NUM),
    .VALID_SIGNAL (VALID_SIGNAL),
    .STABLE_CYCLES(STABLE_CYCLES),
    .IDX_W        (IDX_W)
  ) u_filter (
    .i_clk        (external_clk),
    .i_rstn       (external_rstn),
    .i_seg        (led_display_seg),
    .i_sel        (led_display_sel),
    .o_commit     (w_commit),
    .o_commit_idx (w_commit_idx),
    .o_commit_seg (w_commit_seg)
  );

  for (genvar gi = 0; gi < NUM; gi++) begin : g_digit
    logic [AW-1:0] r_age;
    logic          w_hit;
    logic          w_timeout;

    assign w_hit           = w_commit && (w_commit_idx == IDX_W'(gi));
    assign w_timeout       = (r_age == AGE_PRE);
    assign w_commit_oh[gi] = w_hit;
    // A commit landing on the timeout cycle keeps the digit alive.
    assign w_led_next[gi]   = w_hit ? w_commit_seg : (w_timeout ? 8'h00 : r_led[gi]);
    assign w_valid_next[gi] = w_hit | (r_valid[gi] & ~w_timeout);

    always_ff @(posedge external_clk or negedge external_rstn) begin
      if (!external_rstn) begin
        r_age <= '0;
      end else if (w_hit) begin
        r_age <= '0;
      end else if (r_age != AGE_MAX) begin
        r_age <= r_age + AW'(1);
      end
    end
  end

  assign w_seen_next = r_seen | w_commit_oh;

  always_ff @(posedge external_clk or negedge external_rstn) begin
    if (!external_rstn) begin
      r_led        <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_update     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_led    <= w_led_next;
      r_valid  <= w_valid_next;
      r_update <= (w_led_next != r_led) || (w_valid_next != r_valid);
      if (&w_seen_next) begin
        r_seen       <= '0;
        r_frame_done <= 1'b1;
      end else begin
        r_seen       <= w_seen_next;
        r_frame_done <= 1'b0;
      end
    end
  end

  assign led_out     = r_led;
  assign digit_valid = r_valid;
  assign led_update  = r_update;
  assign frame_done  = r_frame_done;

endmodule
